bambu_ext_mem_responder: RTL and testbench
==========================================

Name: bambu_ext_mem_responder

Overview:
- Off-chip memory slave that sits directly downstream of the HLS accelerator's master memory port (Mout_*) and returns M_Rdata_ram and M_DataRdy to it.
- It models a byte-addressed memory window with a configurable read and write latency, and supports partial-byte writes through the data_ram_size mask.
- It has one independent channel per accelerator memory port.
- Simulation benches instantiate it in place of inline memory logic. A preload port lets the bench fill memory from the values file before start.

Parameters:
- N_CH, 2: number of independent memory channels.
- ADDR_W, 7: address bits per channel.
- DATA_W, 8: data bits per channel (one byte).
- SIZE_W, 4: data_ram_size bits per channel.
- BASE_ADDR, 0: first address of the modelled window.
- MEMSIZE, 32: window size in bytes; legal window is BASE_ADDR <= addr < BASE_ADDR+MEMSIZE.
- READ_DELAY, 2: cycles from the first oe cycle to the DataRdy cycle; must be >= 2.
- WRITE_DELAY, 1: cycles from the first we cycle to the DataRdy cycle; must be >= 1.

Ports:
- clock  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- Mout_oe_ram  in  N_CH  per-channel read enable.
- Mout_we_ram  in  N_CH  per-channel write enable.
- Mout_addr_ram  in  N_CH*ADDR_W  per-channel byte address; channel c uses slice [c*ADDR_W +: ADDR_W].
- Mout_Wdata_ram  in  N_CH*DATA_W  per-channel write data.
- Mout_data_ram_size  in  N_CH*SIZE_W  per-channel access size in bits (0..8).
- M_Rdata_ram  out  N_CH*DATA_W  per-channel read data returned to the accelerator.
- M_DataRdy  out  N_CH  per-channel access-complete strobe.
- load_en  in  1  preload write strobe.
- load_addr  in  ADDR_W  preload address, relative to BASE_ADDR.
- load_data  in  DATA_W  preload byte.
- proto_err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (reset=0, asynchronous): all latency counters = 0, all read-pipeline stages = 0, proto_err = 0. Consequently M_DataRdy = 0 and M_Rdata_ram = 0. Memory contents are NOT cleared by reset.
- Per-channel hit term: hit_c = addr_c inside the window.
- Per-channel counter cnt_c, 32-bit signed, updated each rising edge:
  - oe_c && hit_c: cnt_c <= (cnt_c < READ_DELAY-1) ? cnt_c+1 : 0.
  - else if we_c && hit_c: cnt_c <= (cnt_c < WRITE_DELAY-1) ? cnt_c+1 : 0.
  - otherwise: cnt_c <= 0.
- M_DataRdy[c] is combinational: hit_c && (cnt_c == READ_DELAY-1 || (we_c && cnt_c == WRITE_DELAY-1)).
  - With the defaults, a read is ready in the 2nd cycle of oe; a write is ready in the same cycle we is asserted.
- Read path:
  - raw_c = hit_c ? mem[addr_c - BASE_ADDR] : 0.
  - raw_c passes through a (READ_DELAY-1)-stage register pipeline; M_Rdata_ram slice c = last stage.
  - Read data is therefore aligned with M_DataRdy when oe and the address are held stable.
- Write path, on the rising edge when we_c && hit_c && !oe_c:
  - mask = (1<<size_c)-1, truncated to DATA_W; size 0 gives no change, size >= 8 gives a full byte.
  - mem = (wdata & mask) | (mem & ~mask).
- Out-of-window accesses: no write, read data 0, DataRdy 0, counter held at 0.
- Simultaneous events:
  - Both channels write the same byte: channel N_CH-1 wins (highest index last).
  - load_en in the same cycle as a channel write to the same byte: load wins.
  - A read and a write to the same byte on different channels in the same cycle: the read samples the pre-write value.
- Protocol error: oe_c && we_c in any cycle, regardless of hit:
  - Sets proto_err = 1, sticky until reset.
  - That channel performs no write that cycle and its counter clears to 0.
- Reset asserted mid-access: pending DataRdy and pipeline data are discarded immediately. After release, the access must be reissued from cnt=0.
- The preload port writes the full byte mem[load_addr] when load_en=1 and load_addr < MEMSIZE; otherwise it is ignored.

Test Plan:
- Preload mem[5]=8'hA5; hold ch0 oe=1, addr=5 for 2 cycles -> M_DataRdy[0]=0 in cycle 1, =1 in cycle 2 with M_Rdata_ram[7:0]=8'hA5; ch1 outputs stay 0.
- mem[3]=8'hFF; ch1 we=1, addr=3, wdata=8'h0C, size=4 for 1 cycle -> M_DataRdy[1]=1 in the same cycle; a subsequent read of addr 3 returns 8'hFC.
- ch0 read at addr=40 (out of window) for 4 cycles -> M_DataRdy[0]=0 throughout, M_Rdata_ram[7:0]=0, memory unchanged.
- ch0 oe=1 and we=1 together at addr=2 -> proto_err=1 next edge and stays 1; mem[2] unchanged; proto_err clears only on reset=0.
- Both channels write addr=7 (ch0 8'h11, ch1 8'h22) in the same cycle -> mem[7]=8'h22; adding load_en with load_addr=7, load_data=8'h33 in that cycle -> mem[7]=8'h33.
- Assert reset=0 between cycle 1 and cycle 2 of a read -> M_DataRdy and M_Rdata_ram drop to 0 asynchronously; after release, the read completes 2 cycles after oe is reasserted.

Source files
------------

// File: rtl/bambu_ext_mem_responder_if.sv
// Accelerator-to-memory channel bundle: per-channel request signals from the
// HLS master port and the read-data / completion strobe returned to it.
interface bambu_ext_mem_responder_if #(
  parameter int N_CH   = 2,
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8,
  parameter int SIZE_W = 4
);

  logic [N_CH-1:0]        Mout_oe_ram;
  logic [N_CH-1:0]        Mout_we_ram;
  logic [N_CH*ADDR_W-1:0] Mout_addr_ram;
  logic [N_CH*DATA_W-1:0] Mout_Wdata_ram;
  logic [N_CH*SIZE_W-1:0] Mout_data_ram_size;
  logic [N_CH*DATA_W-1:0] M_Rdata_ram;
  logic [N_CH-1:0]        M_DataRdy;

  // Handshake: a channel request is valid while oe (read) or we (write) is
  // held high with a stable address; M_DataRdy is the one-cycle completion
  // strobe, and the master keeps the request up until it has seen it.
  modport master (
    output Mout_oe_ram,
    output Mout_we_ram,
    output Mout_addr_ram,
    output Mout_Wdata_ram,
    output Mout_data_ram_size,
    input  M_Rdata_ram,
    input  M_DataRdy
  );

  modport slave (
    input  Mout_oe_ram,
    input  Mout_we_ram,
    input  Mout_addr_ram,
    input  Mout_Wdata_ram,
    input  Mout_data_ram_size,
    output M_Rdata_ram,
    output M_DataRdy
  );

endinterface

// File: rtl/bambu_ext_mem_responder.sv
// Byte-addressed external memory model for the HLS master port: per-channel
// latency counters, a registered read pipeline, masked writes and a preload port.
module bambu_ext_mem_responder #(
  parameter int N_CH        = 2,
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int SIZE_W      = 4,
  parameter int BASE_ADDR   = 0,
  parameter int MEMSIZE     = 32,
  parameter int READ_DELAY  = 2,
  parameter int WRITE_DELAY = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  bambu_ext_mem_responder_if.slave bus,
  input  logic                     load_en,
  input  logic [ADDR_W-1:0]        load_addr,
  input  logic [DATA_W-1:0]        load_data,
  output logic                     proto_err
);

  localparam int IDX_W  = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;
  localparam int RD_STG = READ_DELAY - 1;

  logic [DATA_W-1:0] mem_q [MEMSIZE];

  logic [N_CH-1:0]   oe;
  logic [N_CH-1:0]   we;
  logic [N_CH-1:0]   hit;
  logic [N_CH-1:0]   wr_en;
  logic [N_CH-1:0]   rdy;
  int                addr_int [N_CH];
  logic [IDX_W-1:0]  idx      [N_CH];
  logic [SIZE_W-1:0] size     [N_CH];
  logic [DATA_W-1:0] wdata    [N_CH];
  logic [DATA_W-1:0] mask     [N_CH];
  logic [DATA_W-1:0] raw      [N_CH];
  logic [DATA_W-1:0] wr_byte  [N_CH];

  logic signed [31:0] cnt_q [N_CH];
  logic signed [31:0] cnt_d [N_CH];
  logic [DATA_W-1:0]  pipe_q [N_CH][RD_STG];
  logic               proto_err_q;
  logic               proto_err_d;

  logic                   load_ok;
  logic [IDX_W-1:0]       load_idx;
  logic [N_CH*DATA_W-1:0] rdata;

  // Unpack the flat channel buses and decode window hits.
  always_comb begin
    oe = '0;
    we = '0;
    hit = '0;
    wr_en = '0;
    for (int c = 0; c < N_CH; c++) begin
      oe[c]       = bus.Mout_oe_ram[c];
      we[c]       = bus.Mout_we_ram[c];
      addr_int[c] = int'(bus.Mout_addr_ram[c*ADDR_W +: ADDR_W]);
      size[c]     = bus.Mout_data_ram_size[c*SIZE_W +: SIZE_W];
      wdata[c]    = bus.Mout_Wdata_ram[c*DATA_W +: DATA_W];
      hit[c]      = (addr_int[c] >= BASE_ADDR) && (addr_int[c] < BASE_ADDR + MEMSIZE);
      idx[c]      = IDX_W'(addr_int[c] - BASE_ADDR);
      mask[c]     = DATA_W'((64'd1 << size[c]) - 64'd1);
      raw[c]      = hit[c] ? mem_q[idx[c]] : '0;
      wr_en[c]    = we[c] && hit[c] && !oe[c];
    end
  end

  // Writes to the same byte apply in channel order, so a higher channel
  // merges its mask on top of what the lower channels already wrote.
  always_comb begin
    logic [DATA_W-1:0] base;
    base = '0;
    for (int c = 0; c < N_CH; c++) begin
      base = mem_q[idx[c]];
      for (int j = 0; j < c; j++) begin
        if (wr_en[j] && (idx[j] == idx[c])) begin
          base = wr_byte[j];
        end
      end
      wr_byte[c] = (wdata[c] & mask[c]) | (base & ~mask[c]);
    end
  end

  always_comb begin
    load_ok  = load_en && (int'(load_addr) < MEMSIZE);
    load_idx = IDX_W'(load_addr);
  end

  // Latency counters; an oe+we collision restarts the channel.
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      cnt_d[c] = '0;
      if (oe[c] && we[c]) begin
        cnt_d[c] = '0;
      end else if (oe[c] && hit[c]) begin
        cnt_d[c] = (cnt_q[c] < READ_DELAY - 1) ? cnt_q[c] + 32'sd1 : 32'sd0;
      end else if (we[c] && hit[c]) begin
        cnt_d[c] = (cnt_q[c] < WRITE_DELAY - 1) ? cnt_q[c] + 32'sd1 : 32'sd0;
      end
    end
    proto_err_d = proto_err_q || (|(oe & we));
  end

  always_comb begin
    rdata = '0;
    rdy   = '0;
    for (int c = 0; c < N_CH; c++) begin
      rdata[c*DATA_W +: DATA_W] = pipe_q[c][RD_STG-1];
      rdy[c] = hit[c] && ((cnt_q[c] == READ_DELAY - 1) ||
                          (we[c] && (cnt_q[c] == WRITE_DELAY - 1)));
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < N_CH; c++) begin
        cnt_q[c] <= '0;
        for (int s = 0; s < RD_STG; s++) begin
          pipe_q[c][s] <= '0;
        end
      end
      proto_err_q <= 1'b0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        cnt_q[c]     <= cnt_d[c];
        pipe_q[c][0] <= raw[c];
        for (int s = 1; s < RD_STG; s++) begin
          pipe_q[c][s] <= pipe_q[c][s-1];
        end
      end
      proto_err_q <= proto_err_d;
    end
  end

  // Memory contents survive reset; the preload write is issued last so it
  // overrides any channel write to the same byte.
  always_ff @(posedge clock) begin
    for (int c = 0; c < N_CH; c++) begin
      if (wr_en[c]) begin
        mem_q[idx[c]] <= wr_byte[c];
      end
    end
    if (load_ok) begin
      mem_q[load_idx] <= load_data;
    end
  end

  assign bus.M_Rdata_ram = rdata;
  assign bus.M_DataRdy   = rdy;
  assign proto_err       = proto_err_q;

endmodule

// File: tb/tb_bambu_ext_mem_responder.sv
// Bench for bambu_ext_mem_responder: slot-based stimulus, a byte-array memory
// model and per-channel expected queues drained by a negedge monitor.
module tb_bambu_ext_mem_responder;

  localparam int N_CH        = 2;
  localparam int ADDR_W      = 7;
  localparam int DATA_W      = 8;
  localparam int SIZE_W      = 4;
  localparam int BASE_ADDR   = 0;
  localparam int MEMSIZE     = 32;
  localparam int READ_DELAY  = 2;
  localparam int WRITE_DELAY = 1;
  localparam int EW          = 42;  // {kind[1:0], cycle[31:0], data[7:0]}

  localparam logic [1:0] K_RD = 2'd0;
  localparam logic [1:0] K_WR = 2'd1;
  localparam logic [1:0] K_PE = 2'd2;

  localparam int OP_IDLE = 0;
  localparam int OP_RD   = 1;
  localparam int OP_WR   = 2;
  localparam int OP_PE   = 3;
  localparam int IDLE_A  = 127;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              proto_err;

  bambu_ext_mem_responder_if #(
    .N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE_W(SIZE_W)
  ) bus ();

  bambu_ext_mem_responder #(
    .N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE_W(SIZE_W),
    .BASE_ADDR(BASE_ADDR), .MEMSIZE(MEMSIZE),
    .READ_DELAY(READ_DELAY), .WRITE_DELAY(WRITE_DELAY)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .proto_err (proto_err)
  );

  // ---------------- reference model + scoreboard ----------------
  logic [7:0]    mem_m [MEMSIZE];
  logic          proto_m;
  logic [EW-1:0] exp_q0[$];
  logic [EW-1:0] exp_q1[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit in_win(input int a);
    return (a >= BASE_ADDR) && (a < BASE_ADDR + MEMSIZE);
  endfunction

  function automatic logic [7:0] size_mask(input int sz);
    if (sz >= 8) return 8'hFF;
    return 8'((1 << sz) - 1);
  endfunction

  task automatic push(input int c, input logic [1:0] kind, input int when, input logic [7:0] d);
    logic [EW-1:0] e;
    e = {kind, 32'(when), d};
    if (c == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  task automatic mon_channel(input int c);
    logic [EW-1:0] e;
    int            depth;
    depth = (c == 0) ? exp_q0.size() : exp_q1.size();
    if (depth == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL ch%0d unexpected DataRdy: got 1, expected 0 (cycle %0d)", c, cyc);
    end else begin
      if (c == 0) e = exp_q0.pop_front();
      else        e = exp_q1.pop_front();
      check($sformatf("ch%0d DataRdy cycle", c), 32'(cyc), e[39:8]);
      if (e[41:40] == K_RD) begin
        check($sformatf("ch%0d read data", c),
              32'(bus.M_Rdata_ram[c*DATA_W +: DATA_W]), 32'(e[7:0]));
      end
    end
  endtask

  always @(negedge clock) begin
    if (reset) begin
      if (bus.M_DataRdy[0] === 1'b1) mon_channel(0);
      if (bus.M_DataRdy[1] === 1'b1) mon_channel(1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    bus.Mout_oe_ram        = '0;
    bus.Mout_we_ram        = '0;
    bus.Mout_addr_ram      = {N_CH{7'(IDLE_A)}};
    bus.Mout_Wdata_ram     = '0;
    bus.Mout_data_ram_size = '0;
    load_en   = 1'b0;
    load_addr = '0;
    load_data = '0;
  endtask

  // One slot: both channels issue one operation, held for its latency, then one idle cycle.
  task automatic run_slot(input int k0, input int a0, input int w0, input int s0,
                          input int k1, input int a1, input int w1, input int s1,
                          input bit le, input int la, input int ld, input int hold);
    int kind [2];
    int addr [2];
    int wd   [2];
    int sz   [2];
    int start;
    int len;
    int rd_len;
    kind[0] = k0; addr[0] = a0; wd[0] = w0; sz[0] = s0;
    kind[1] = k1; addr[1] = a1; wd[1] = w1; sz[1] = s1;
    rd_len = (hold > 0) ? hold : READ_DELAY;
    len = 1;
    for (int c = 0; c < 2; c++) begin
      if (kind[c] == OP_RD && rd_len > len)      len = rd_len;
      if (kind[c] == OP_WR && WRITE_DELAY > len) len = WRITE_DELAY;
    end

    @(posedge clock); #1;
    start = cyc;
    for (int c = 0; c < 2; c++) begin
      if (in_win(addr[c])) begin
        case (kind[c])
          OP_RD: push(c, K_RD, start + READ_DELAY - 1, mem_m[addr[c] - BASE_ADDR]);
          OP_WR: push(c, K_WR, start + WRITE_DELAY - 1, 8'h00);
          OP_PE: push(c, K_PE, start, 8'h00);
          default: ;
        endcase
      end
      if (kind[c] == OP_PE) proto_m = 1'b1;
    end
    for (int c = 0; c < 2; c++) begin
      if (kind[c] == OP_WR && in_win(addr[c])) begin
        mem_m[addr[c] - BASE_ADDR] = (8'(wd[c]) & size_mask(sz[c])) |
                                     (mem_m[addr[c] - BASE_ADDR] & ~size_mask(sz[c]));
      end
    end
    if (le && la < MEMSIZE) mem_m[la] = 8'(ld);

    for (int k = 0; k < len; k++) begin
      if (k > 0) begin
        @(posedge clock); #1;
      end
      for (int c = 0; c < 2; c++) begin
        bus.Mout_addr_ram[c*ADDR_W +: ADDR_W]      = 7'(addr[c]);
        bus.Mout_Wdata_ram[c*DATA_W +: DATA_W]     = 8'(wd[c]);
        bus.Mout_data_ram_size[c*SIZE_W +: SIZE_W] = 4'(sz[c]);
        bus.Mout_oe_ram[c] = (kind[c] == OP_RD && k < rd_len) || (kind[c] == OP_PE && k == 0);
        bus.Mout_we_ram[c] = (kind[c] == OP_WR && k < WRITE_DELAY) || (kind[c] == OP_PE && k == 0);
      end
      load_en   = le && (k == 0);
      load_addr = 7'(la);
      load_data = 8'(ld);
      @(negedge clock);
      for (int c = 0; c < 2; c++) begin
        if (!in_win(addr[c])) begin
          check($sformatf("ch%0d out-of-window rdata", c),
                32'(bus.M_Rdata_ram[c*DATA_W +: DATA_W]), 32'h0);
          check($sformatf("ch%0d out-of-window rdy", c), 32'(bus.M_DataRdy[c]), 32'h0);
        end
      end
    end
    @(posedge clock); #1;
    drive_idle();
    check("proto_err", 32'(proto_err), 32'(proto_m));
  endtask

  task automatic preload(input int a, input int d);
    run_slot(OP_IDLE, IDLE_A, 0, 0, OP_IDLE, IDLE_A, 0, 0, 1'b1, a, d, 0);
  endtask

  task automatic read0(input int a);
    run_slot(OP_RD, a, 0, 0, OP_IDLE, IDLE_A, 0, 0, 1'b0, 0, 0, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int start;
    drive_idle();
    proto_m = 1'b0;
    #1 reset = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    check("reset DataRdy", 32'(bus.M_DataRdy), 32'h0);
    check("reset Rdata", 32'(bus.M_Rdata_ram), 32'h0);
    check("reset proto_err", 32'(proto_err), 32'h0);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < MEMSIZE; i++) begin
      preload(i, (i == 5) ? 8'hA5 : (i == 3) ? 8'hFF : $urandom_range(0, 255));
    end
    preload(40, 8'h5A);
    run_slot(OP_RD, 8, 0, 0, OP_RD, 31, 0, 0, 1'b0, 0, 0, 0);

    read0(5);
    run_slot(OP_IDLE, IDLE_A, 0, 0, OP_WR, 3, 8'h0C, 4, 1'b0, 0, 0, 0);
    read0(3);
    run_slot(OP_RD, 40, 0, 0, OP_RD, 32, 0, 0, 1'b0, 0, 0, 4);
    run_slot(OP_PE, 2, 8'h77, 8, OP_IDLE, IDLE_A, 0, 0, 1'b0, 0, 0, 0);
    read0(2);
    run_slot(OP_WR, 7, 8'h11, 8, OP_WR, 7, 8'h22, 8, 1'b0, 0, 0, 0);
    read0(7);
    run_slot(OP_WR, 7, 8'h11, 8, OP_WR, 7, 8'h22, 8, 1'b1, 7, 8'h33, 0);
    read0(7);
    run_slot(OP_WR, 9, 8'h00, 0, OP_WR, 10, 8'h5C, 12, 1'b0, 0, 0, 0);
    run_slot(OP_RD, 9, 0, 0, OP_RD, 10, 0, 0, 1'b0, 0, 0, 0);
    run_slot(OP_WR, 12, 8'hF0, 6, OP_WR, 12, 8'h0F, 2, 1'b0, 0, 0, 0);
    run_slot(OP_RD, 12, 0, 0, OP_WR, 12, 8'hAA, 8, 1'b0, 0, 0, 0);
    read0(12);

    repeat (300) begin
      int k [2];
      int a [2];
      int r;
      bit le;
      for (int c = 0; c < 2; c++) begin
        r = $urandom_range(0, 99);
        k[c] = (r < 15) ? OP_IDLE : (r < 55) ? OP_RD : (r < 95) ? OP_WR : OP_PE;
        a[c] = (k[c] == OP_IDLE) ? IDLE_A : $urandom_range(0, 39);
      end
      if ($urandom_range(0, 3) == 0 && k[1] != OP_IDLE) a[1] = a[0];
      le = ($urandom_range(0, 9) == 0);
      run_slot(k[0], a[0], $urandom_range(0, 255), $urandom_range(0, 10),
               k[1], a[1], $urandom_range(0, 255), $urandom_range(0, 10),
               le, $urandom_range(0, 35), $urandom_range(0, 255), 0);
    end

    // Reset in the middle of a read: the pending strobe and data vanish at once.
    @(posedge clock); #1;
    start = cyc;
    bus.Mout_addr_ram[0 +: ADDR_W] = 7'd5;
    bus.Mout_oe_ram[0] = 1'b1;
    @(negedge clock);
    check("mid-reset cycle1 rdy", 32'(bus.M_DataRdy[0]), 32'h0);
    @(posedge clock); #1;
    check("mid-reset cycle2 rdy", 32'(bus.M_DataRdy[0]), 32'h1);
    check("mid-reset cycle2 data", 32'(bus.M_Rdata_ram[7:0]), 32'(mem_m[5]));
    reset = 1'b0;
    #1;
    check("async reset rdy", 32'(bus.M_DataRdy), 32'h0);
    check("async reset rdata", 32'(bus.M_Rdata_ram), 32'h0);
    check("async reset proto_err", 32'(proto_err), 32'h0);
    drive_idle();
    proto_m = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    read0(5);
    read0(7);
    check("ch0 queue drained", 32'(exp_q0.size()), 32'h0);
    check("ch1 queue drained", 32'(exp_q1.size()), 32'h0);
    check("cycles since mid-reset read", 32'(cyc - start < 100), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
